// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: parses a framed program image, writes it into
// instruction memory word by word and holds the core in reset until it checks out.
module imem_boot_loader #(
  parameter int         N              = 32,
  parameter int         IMEM_DEPTH     = 76,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic         i_clk,
  input  logic         i_arst,
  input  logic         i_rx_valid,
  input  logic [7:0]   i_rx_data,
  output logic         o_rx_ready,
  output logic         o_imem_we,
  output logic [N-1:0] o_imem_addr,
  output logic [N-1:0] o_imem_wdata,
  output logic         o_core_rst,
  output logic         o_done,
  output logic         o_err,
  output logic [15:0]  o_word_cnt
);

  localparam logic [2:0] S_SYNC  = 3'd0;
  localparam logic [2:0] S_LEN0  = 3'd1;
  localparam logic [2:0] S_LEN1  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_CHK   = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_ERR   = 3'd7;

  localparam logic [15:0] DEPTH_W  = 16'(IMEM_DEPTH);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);

  logic [2:0]  state;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [1:0]  byte_idx;
  logic [31:0] word;
  logic [7:0]  chk;
  logic [31:0] tmo_cnt;

  logic        accept;
  logic        timed;
  logic        timeout;
  logic [7:0]  chk_next;
  logic [15:0] len_next;
  logic [31:0] word_next;

  assign o_rx_ready = (state != S_WRITE);
  assign accept     = i_rx_valid && o_rx_ready;
  assign chk_next   = chk + i_rx_data;
  assign len_next   = {i_rx_data, len_lo};
  assign timed      = (state == S_LEN0) || (state == S_LEN1) ||
                      (state == S_DATA) || (state == S_CHK);
  // A byte arriving on the final idle cycle wins over the timeout.
  assign timeout    = TMO_EN && timed && !accept && (tmo_cnt == TMO_LAST);

  // NOTE: give every always_comb output a default first so no latch is inferred.
  always_comb begin
    word_next = word;
    word_next[{byte_idx, 3'b000} +: 8] = i_rx_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state        <= S_SYNC;
      len_lo       <= '0;
      len          <= '0;
      byte_idx     <= '0;
      word         <= '0;
      chk          <= '0;
      tmo_cnt      <= '0;
      o_imem_we    <= 1'b0;
      o_imem_addr  <= '0;
      o_imem_wdata <= '0;
      o_core_rst   <= 1'b1;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
      o_word_cnt   <= '0;
    end else begin
      if (!TMO_EN || accept || !timed || timeout) tmo_cnt <= '0;
      else                                        tmo_cnt <= tmo_cnt + 32'd1;

      // Strobe is raised only on the transition into WRITE, so it lasts one cycle.
      o_imem_we <= 1'b0;

      if (timeout) begin
        state <= S_ERR;
        o_err <= 1'b1;
      end else begin
        case (state)
          S_SYNC, S_DONE, S_ERR: begin
            if (accept && (i_rx_data == SYNC_BYTE)) begin
              state      <= S_LEN0;
              o_done     <= 1'b0;
              o_err      <= 1'b0;
              o_word_cnt <= '0;
              chk        <= '0;
              o_core_rst <= 1'b1;
              byte_idx   <= '0;
              word       <= '0;
            end
          end
          S_LEN0: begin
            if (accept) begin
              len_lo <= i_rx_data;
              chk    <= chk_next;
              state  <= S_LEN1;
            end
          end
          S_LEN1: begin
            if (accept) begin
              len <= len_next;
              chk <= chk_next;
              if (len_next > DEPTH_W) begin
                state <= S_ERR;
                o_err <= 1'b1;
              end else if (len_next == 16'd0) begin
                state <= S_CHK;
              end else begin
                state <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (accept) begin
              chk      <= chk_next;
              word     <= word_next;
              byte_idx <= byte_idx + 2'd1;
              if (byte_idx == 2'd3) begin
                state        <= S_WRITE;
                o_imem_we    <= (o_word_cnt < DEPTH_W);
                o_imem_addr  <= N'({o_word_cnt, 2'b00});
                o_imem_wdata <= N'(word_next);
              end
            end
          end
          S_WRITE: begin
            o_word_cnt <= o_word_cnt + 16'd1;
            if ((o_word_cnt + 16'd1) < len) state <= S_DATA;
            else                            state <= S_CHK;
          end
          S_CHK: begin
            if (accept) begin
              chk <= chk_next;
              if (chk_next == 8'd0) begin
                state      <= S_DONE;
                o_done     <= 1'b1;
                o_core_rst <= 1'b0;
              end else begin
                state <= S_ERR;
                o_err <= 1'b1;
              end
            end
          end
          default: state <= S_SYNC;
        endcase
      end
    end
  end

endmodule
